mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//  Sequential shift-add controller for unsigned WIDTHxWIDTH multiplication.
//  Spends WIDTH cycles to compute the same product as the combinational
//  array multiplier, in far less area.
//  Sits between a requester (valid/ready in) and a consumer (valid/ready out).
//  Holds the result until the consumer accepts it.
// PARAMETERS
//  WIDTH  8  operand width in bits; product is 2*WIDTH bits; legal range 2..32
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        reset, asynchronous assert, active-low
//  req_valid  in   1        operands valid
//  req_ready  out  1        controller can accept operands (IDLE only)
//  top        in   WIDTH    multiplicand, sampled on the req handshake
//  bottom     in   WIDTH    multiplier, sampled on the req handshake
//  res_valid  out  1        product valid (DONE only)
//  res_ready  in   1        consumer accepts product
//  product    out  2*WIDTH  unsigned top*bottom; meaningful only while res_valid=1
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  - One clock domain: clk. Reset is asynchronous and active-low on rst_n.
//  - Reset (rst_n=0): state=IDLE; acc, mcand, mplier, cnt=0.
//    Outputs: req_ready=1, res_valid=0, busy=0, product=0.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE, req_valid&req_ready at an edge:
//    mcand<={WIDTH'b0,top}, mplier<=bottom, acc<=0, cnt<=0, go to RUN.
//  - RUN, each edge:
//    if mplier[0], acc<=acc+mcand (2*WIDTH-bit add, never overflows);
//    then mcand<<=1, mplier>>=1, cnt<=cnt+1.
//    When cnt==WIDTH-1 on that edge, go to DONE.
//  - DONE: res_valid=1, product=acc, held stable while res_ready=0.
//    res_valid&res_ready at an edge: go to IDLE. product keeps acc until the next accept.
//  - Latency: res_valid rises exactly WIDTH cycles after the accepting edge.
//    With res_ready held high, one result every WIDTH+2 cycles.
//  - req_ready=0 in RUN and DONE; req_valid there is ignored.
//    No accept can happen in the same cycle as a result handshake.
//  - Top and bottom are sampled only at accept. Later changes do not affect the operation in flight.
//  - rst_n low mid-RUN or mid-DONE: operation is dropped, no res_valid, back to reset values.
//  - Operand zero: full latency still applies without the option below; product=0.
//  - Illegal state encoding: next state=IDLE.
// CONFIGURATION
//  Macro MULT_SEQ_EARLY_TERM_EN.
//  - Defined: in RUN, if mplier==0 at an edge, go to DONE on that edge with acc unchanged.
//    Latency becomes min(msb_index(bottom)+2, WIDTH), with bottom=0 giving 1.
//  - Undefined: latency is always WIDTH. No zero-detect logic is built.
//  - Product values are identical in both builds.
// STRUCTURE
//  - Package mult_pkg holds:
//    state typedef enum logic[1:0] {IDLE,RUN,DONE};
//    MULT_W_DEFAULT=8;
//    function clog2-based CNT_W(WIDTH) for the cnt width.
//  - Sub-module mult_seq_dp: mcand/mplier/acc registers, adder, and shifts.
//    Its controls (load, step) are driven by the FSM in mult_seq_ctrl.
//  - The FSM and cnt stay in mult_seq_ctrl.
// TESTING
//  - top=0x0A, bottom=0x0E, res_ready=1 -> product=0x008C; res_valid high 8 cycles after accept, for 1 cycle.
//  - top=0xFF, bottom=0xFF -> product=0xFE01; busy high 9 cycles; req_ready low until the result handshake.
//  - 0x12*0x34, res_ready low 5 cycles -> product=0x03A8 held stable, res_valid high 5+1 cycles.
//    req_valid with new operands during that time is not accepted.
//  - Reset mid-RUN: rst_n low at cycle 3 of 0x55*0x03 -> outputs go to reset values immediately.
//    Next op 0x02*0x03 gives 0x0006.
//  - With MULT_SEQ_EARLY_TERM_EN: bottom=0x00 -> product 0, latency 1; bottom=0x01, top=0x7F -> 0x007F, latency 2.
//    Without the macro, both cases have latency 8.
//  - Random: 2000 back-to-back ops with random res_ready gaps -> every product equals top*bottom.
//    No lost or duplicate results.

Source files
------------

// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Optional build macro used by this slice: MULT_SEQ_EARLY_TERM_EN
// (early exit from RUN once the remaining multiplier bits are all zero).
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MULT_W_DEFAULT = 8;

  // Counter width able to hold 0..width-1; never narrower than one bit.
  function automatic int CNT_W(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Requester/consumer handshake bundle for the sequential multiplier.
// The controller side uses the slave modport; the bench/system side uses master.
// Optional build macro affecting the slice: MULT_SEQ_EARLY_TERM_EN (no effect here).
interface mult_seq_ctrl_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W_DEFAULT
);

  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   top;
  logic [WIDTH-1:0]   bottom;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output req_valid, top, bottom, res_ready,
    input  req_ready, res_valid, product, busy
  );

  modport slave (
    input  req_valid, top, bottom, res_ready,
    output req_ready, res_valid, product, busy
  );

endinterface

// File: rtl/mult_seq_ctrl_dp.sv
// Datapath of the shift-add multiplier: multiplicand, multiplier and
// accumulator registers with the adder and shifters.
// load_i captures fresh operands and clears the accumulator; step_i performs
// one conditional add followed by the shifts.
// With MULT_SEQ_EARLY_TERM_EN defined, a multiplier-is-zero flag is exported.
module mult_seq_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   top_i,
  input  logic [WIDTH-1:0]   bottom_i,
`ifdef MULT_SEQ_EARLY_TERM_EN
  output logic               mplier_zero_o,
`endif
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  // Next-value selection: load has priority over step; otherwise hold.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, top_i};
      mplier_d = bottom_i;
      acc_d    = '0;
    end else if (step_i) begin
      // The widened add cannot overflow: the final product fits 2*WIDTH bits.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // Operand and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

`ifdef MULT_SEQ_EARLY_TERM_EN
  assign mplier_zero_o = (mplier_q == '0);
`endif

  assign acc_o = acc_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier controller: accepts operands on a
// valid/ready request, spends up to WIDTH cycles stepping the datapath,
// then holds the product until the consumer takes it.
// Build macro MULT_SEQ_EARLY_TERM_EN: when defined, RUN ends as soon as the
// remaining multiplier bits are zero (product unchanged, latency shorter).
//
// state | meaning
// IDLE  | waiting for operands, req_ready high
// RUN   | one shift-add step per cycle, cnt counts steps
// DONE  | product valid, waiting for res_ready
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_seq_ctrl_if.slave mult_if
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  localparam int            CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               load;
  logic               step;
  logic               term;
  logic               last;
  logic [2*WIDTH-1:0] acc;

`ifdef MULT_SEQ_EARLY_TERM_EN
  logic mplier_zero;
  assign term = (state_q == S_RUN) && mplier_zero;
`else
  assign term = 1'b0;
`endif

  assign load = (state_q == S_IDLE) && mult_if.req_valid;
  assign step = (state_q == S_RUN) && !term;
  assign last = (cnt_q == CNT_LAST);

  // Next-state and step-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (term) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (mult_if.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mult_seq_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load),
    .step_i        (step),
    .top_i         (mult_if.top),
    .bottom_i      (mult_if.bottom),
`ifdef MULT_SEQ_EARLY_TERM_EN
    .mplier_zero_o (mplier_zero),
`endif
    .acc_o         (acc)
  );

  assign mult_if.req_ready = (state_q == S_IDLE);
  assign mult_if.busy      = (state_q != S_IDLE);
  assign mult_if.res_valid = (state_q == S_DONE);
  // acc is frozen in DONE and until the next load, so it doubles as the result.
  assign mult_if.product   = acc;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: directed cases with hand-computed results plus a
// long randomized back-to-back run, all checked each cycle against a
// transaction-level model (product = top*bottom, fixed latency per operand).
// Honours MULT_SEQ_EARLY_TERM_EN for the expected latency.
module tb_mult_seq_ctrl;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mult_seq_ctrl_if #(.WIDTH(W)) bus ();

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mult_if (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Latency in cycles from the accepting edge to res_valid.
  function automatic int latency(input logic [W-1:0] b);
`ifdef MULT_SEQ_EARLY_TERM_EN
    int msb;
    if (b == '0) return 1;
    msb = 0;
    for (int i = 0; i < W; i++) if (b[i]) msb = i;
    return (msb + 2 < W) ? msb + 2 : W;
`else
    return W;
`endif
  endfunction

  // Transaction model: 0 = waiting for operands, 1 = computing, 2 = result held.
  int              m_phase = 0;
  int              m_left  = 0;
  logic [PW-1:0]   m_prod  = '0;
  int              m_acc = 0, m_res = 0, d_acc = 0, d_res = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs",
            64'({bus.req_ready, bus.busy, bus.res_valid, bus.product}),
            64'({1'b1, 1'b0, 1'b0, {PW{1'b0}}}));
        m_phase = 0;
        m_left  = 0;
      end else begin
        chk("ctrl_flags",
            64'({bus.req_ready, bus.busy, bus.res_valid}),
            64'({m_phase == 0, m_phase != 0, m_phase == 2}));
        if (m_phase == 2) chk("product", 64'(bus.product), 64'(m_prod));
        if (bus.req_valid && bus.req_ready) d_acc++;
        if (bus.res_valid && bus.res_ready) d_res++;
        case (m_phase)
          0: if (bus.req_valid) begin
            m_phase = 1;
            m_left  = latency(bus.bottom);
            m_prod  = PW'(bus.top) * PW'(bus.bottom);
            m_acc++;
          end
          1: begin
            m_left--;
            if (m_left == 0) m_phase = 2;
          end
          default: if (bus.res_ready) begin
            m_phase = 0;
            m_res++;
          end
        endcase
      end
    end
  end

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return W'(1);
      3:       return W'(1 << $urandom_range(0, W - 1));
      default: return W'($urandom);
    endcase
  endfunction

  // One operation; entered and left just after a rising edge with the DUT idle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                       input bit pester, output int lat, output int bcyc, output int vcyc,
                       output logic [PW-1:0] prod, output bit stable, output bit rr_low);
    int n;
    bus.req_valid = 1'b1;
    bus.top       = a;
    bus.bottom    = b;
    bus.res_ready = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid = pester;
    lat    = 0;
    bcyc   = bus.busy ? 1 : 0;
    vcyc   = 0;
    stable = 1'b1;
    rr_low = !bus.req_ready;
    while (!bus.res_valid && lat < 40) begin
      if (pester) begin bus.top = W'($urandom); bus.bottom = W'($urandom); end
      @(posedge clk); #1;
      lat++;
      if (bus.busy) bcyc++;
      if (bus.req_ready) rr_low = 1'b0;
    end
    prod = bus.product;
    n = 0;
    while (bus.res_valid && n < 40) begin
      vcyc++;
      if (bus.product !== prod) stable = 1'b0;
      if (bus.req_ready) rr_low = 1'b0;
      if (pester) begin bus.top = W'($urandom); bus.bottom = W'($urandom); end
      if (n >= hold) bus.res_ready = 1'b1;
      @(posedge clk); #1;
      n++;
      if (bus.busy) bcyc++;
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
  endtask

  int            lat, bcyc, vcyc, base, cyc;
  logic [PW-1:0] prod;
  bit            stable, rr_low;

  initial begin
    bus.req_valid = 1'b0;
    bus.top       = '0;
    bus.bottom    = '0;
    bus.res_ready = 1'b1;

    @(posedge clk); #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_product",   64'(bus.product),   64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(8'h0A, 8'h0E, 0, 1'b0, lat, bcyc, vcyc, prod, stable, rr_low);
    chk("a_product",  64'(prod), 64'h008C);
    chk("a_latency",  64'(lat),  64'd8);
    chk("a_valid_cy", 64'(vcyc), 64'd1);

    do_op(8'hFF, 8'hFF, 0, 1'b0, lat, bcyc, vcyc, prod, stable, rr_low);
    chk("b_product",  64'(prod),   64'hFE01);
    chk("b_busy_cy",  64'(bcyc),   64'd9);
    chk("b_rdy_low",  64'(rr_low), 64'd1);

    do_op(8'h12, 8'h34, 5, 1'b1, lat, bcyc, vcyc, prod, stable, rr_low);
    chk("c_product",  64'(prod),   64'h03A8);
    chk("c_valid_cy", 64'(vcyc),   64'd6);
    chk("c_stable",   64'(stable), 64'd1);
    chk("c_rdy_low",  64'(rr_low), 64'd1);
    chk("c_no_accept_at_result", 64'(bus.busy), 64'd0);

    bus.req_valid = 1'b1;
    bus.top       = 8'h55;
    bus.bottom    = 8'h03;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("d_rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("d_rst_busy",      64'(bus.busy),      64'd0);
    chk("d_rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("d_rst_product",   64'(bus.product),   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(8'h02, 8'h03, 0, 1'b0, lat, bcyc, vcyc, prod, stable, rr_low);
    chk("d_product", 64'(prod), 64'h0006);

    do_op(8'h7F, 8'h00, 0, 1'b0, lat, bcyc, vcyc, prod, stable, rr_low);
    chk("e_zero_product", 64'(prod), 64'h0000);
`ifdef MULT_SEQ_EARLY_TERM_EN
    chk("e_zero_latency", 64'(lat), 64'd1);
`else
    chk("e_zero_latency", 64'(lat), 64'd8);
`endif
    do_op(8'h7F, 8'h01, 0, 1'b0, lat, bcyc, vcyc, prod, stable, rr_low);
    chk("e_one_product", 64'(prod), 64'h007F);
`ifdef MULT_SEQ_EARLY_TERM_EN
    chk("e_one_latency", 64'(lat), 64'd2);
`else
    chk("e_one_latency", 64'(lat), 64'd8);
`endif

    base = m_res;
    cyc  = 0;
    while ((m_res - base) < 2000 && cyc < 60000) begin
      bus.req_valid = 1'b1;
      bus.top       = rnd();
      bus.bottom    = rnd();
      bus.res_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    chk("rand_results", 64'(m_res - base), 64'd2000);
    chk("accept_count", 64'(d_acc), 64'(m_acc));
    chk("result_count", 64'(d_res), 64'(m_res));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
